// File: rtl/plic_gateway.sv
// Per-source interrupt gateway in front of the PLIC: turns raw level/edge lines into one-cycle requests.
// Define PLIC_GW_SYNC_EN to add a 2-flop synchronizer on each src_irq bit (asynchronous device domains).
module plic_gateway #(
    parameter int NSRC  = 2,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_irq,
    input  logic [NSRC-1:0] src_edge,
    input  logic [NSRC-1:0] gw_enable,
    input  logic [NSRC-1:0] complete,
    input  logic [NSRC-1:0] ovf_clr,
    output logic [NSRC-1:0] irq_req,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } gw_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NSRC-1:0] s_q;
    logic [NSRC-1:0] s_prev_q;
    logic [NSRC-1:0] new_edge;

`ifdef PLIC_GW_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
        end else begin
            sync1_q  <= src_irq;
            sync2_q  <= sync1_q;
            s_q      <= sync2_q;
            s_prev_q <= s_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            s_prev_q <= '0;
        end else begin
            s_q      <= src_irq;
            s_prev_q <= s_q;
        end
    end
`endif

    assign new_edge = s_q & ~s_prev_q;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        gw_state_e        state_q;
        gw_state_e        state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             ovf_q;
        logic             ovf_d;
        logic             cnt_nz;
        logic             avail;
        logic             take;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
            end
        end

        always_comb begin
            cnt_nz  = (cnt_q != '0);
            avail   = gw_enable[i] & (src_edge[i] ? (cnt_nz | new_edge[i]) : s_q[i]);
            take    = (state_q == ST_IDLE) & avail;
            state_d = state_q;
            cnt_d   = cnt_q;
            ovf_d   = ovf_q;

            unique case (state_q)
                ST_IDLE: if (avail) state_d = ST_FIRE;
                ST_FIRE: state_d = ST_WAIT;
                ST_WAIT: if (complete[i]) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            // A same-cycle saturation drop overrides the software clear below.
            if (ovf_clr[i]) ovf_d = 1'b0;

            if (!src_edge[i] || !gw_enable[i]) begin
                cnt_d = '0;
            end else if (take) begin
                // Taking a queued edge while a new one arrives leaves the count unchanged.
                if (cnt_nz && !new_edge[i]) cnt_d = cnt_q - CNT_ONE;
            end else if (new_edge[i]) begin
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + CNT_ONE;
            end
        end

        assign irq_req[i]    = (state_q == ST_FIRE);
        assign in_service[i] = (state_q == ST_WAIT);
        assign ovf[i]        = ovf_q;
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Table-driven bench for plic_gateway (NSRC=2, CNT_W=2) with an expected-output scoreboard queue.
`timescale 1ns/1ps
module tb_plic_gateway;

    localparam int NSRC  = 2;
    localparam int CNT_W = 2;
`ifdef PLIC_GW_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NSRC-1:0] src_irq   = '0;
    logic [NSRC-1:0] src_edge  = '0;
    logic [NSRC-1:0] gw_enable = '0;
    logic [NSRC-1:0] complete  = '0;
    logic [NSRC-1:0] ovf_clr   = '0;
    logic [NSRC-1:0] irq_req;
    logic [NSRC-1:0] in_service;
    logic [NSRC-1:0] ovf;

    plic_gateway #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .src_edge   (src_edge),
        .gw_enable  (gw_enable),
        .complete   (complete),
        .ovf_clr    (ovf_clr),
        .irq_req    (irq_req),
        .in_service (in_service),
        .ovf        (ovf)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] irq, edg, en, cmp, clr;
        logic [1:0] req, svc, ov;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic add(input string nm, input logic [1:0] irq, edg, en, cmp, clr, req, svc, ov);
        vec_t v;
        v.name = nm; v.irq = irq; v.edg = edg; v.en = en; v.cmp = cmp; v.clr = clr;
        v.req = req; v.svc = svc; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string nm);
        logic [5:0] a;
        logic [5:0] e;
        a = {irq_req, in_service, ovf};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got req/svc/ovf=%b but no expected entry queued", nm, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got req/svc/ovf=%b required %b", nm, a, e);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
    task automatic drive(input string nm, input logic [1:0] irq, edg, en, cmp, clr, req, svc, ov);
        src_irq = irq; src_edge = edg; gw_enable = en; complete = cmp; ovf_clr = clr;
        exp_q.push_back({req, svc, ov});
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    initial begin
        // Level request on source 1.
        add("lvl", 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("lvl", 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        add("lvl", 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        add("lvl", 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        add("lvl", 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        add("lvl", 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        add("lvl", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        add("lvl", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        add("lvl", 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        add("lvl", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("lvl", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // Edge burst on source 0: first pulse, then three edges queued during WAIT.
        add("burst", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("burst", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add("burst", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        for (int e = 0; e < 3; e++) begin
            add("burst", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
            add("burst", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        end
        for (int n = 0; n < 3; n++) begin
            add("burst_cmp",  2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
            add("burst_fire", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
            add("burst_wait", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        end
        add("burst_cmp",   2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("burst_empty", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("burst_empty", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // Saturation: five edges during WAIT with a 2-bit counter.
        add("sat", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("sat", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add("sat", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        for (int e = 1; e <= 5; e++) begin
            add("sat_edge", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, (e >= 5) ? 2'b01 : 2'b00);
            add("sat_edge", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, (e >= 4) ? 2'b01 : 2'b00);
        end
        add("ovf_clr",      2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        add("ovf_clr",      2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add("ovf_set_wins", 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
        add("ovf_clr",      2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        for (int n = 0; n < 3; n++) begin
            add("sat_cmp",  2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
            add("sat_fire", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
            add("sat_wait", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        end
        add("sat_cmp",   2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("sat_empty", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // Disabled sources ignore a toggling line and leave the counter at zero.
        for (int k = 0; k < 6; k++)
            add("disabled", (k % 2 == 0) ? 2'b11 : 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++)
            add("reenable", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("stray_cmp", 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add("both",      2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("both",      2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add("both",      2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
        add("both",      2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);

        // Power-up asynchronous reset.
        #1 rst = 1'b1;
        #2;
        exp_q.push_back(6'b0);
        check_out("rst_init");
        @(posedge clk);
        #1 rst = 1'b0;

        // First-request latency on an edge source.
        for (int k = 0; k <= LAT + 2; k++)
            drive("latency", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                  (k == LAT) ? 2'b01 : 2'b00, (k > LAT) ? 2'b01 : 2'b00, 2'b00);
        drive("latency_cmp", 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++)
            drive("latency_idle", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

`ifndef PLIC_GW_SYNC_EN
        foreach (vecs[i])
            drive(vecs[i].name, vecs[i].irq, vecs[i].edg, vecs[i].en, vecs[i].cmp, vecs[i].clr,
                  vecs[i].req, vecs[i].svc, vecs[i].ov);
`endif

        // Bring both sources into WAIT, then reset asynchronously mid-cycle.
        for (int k = 0; k <= LAT + 2; k++)
            drive("pre_rst", 2'b11, 2'b00, 2'b11, (k == 0) ? 2'b11 : 2'b00, 2'b00,
                  (k == LAT) ? 2'b11 : 2'b00, (k > LAT) ? 2'b11 : 2'b00, 2'b00);
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(6'b0);
        check_out("rst_async");
        src_irq = 2'b00; src_edge = 2'b01; gw_enable = 2'b01; complete = 2'b00; ovf_clr = 2'b00;
        @(posedge clk);
        #1;
        exp_q.push_back(6'b0);
        check_out("rst_held");
        rst = 1'b0;
        for (int k = 0; k < 4; k++)
            drive("post_rst", 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
